// File: rtl/cmpge_share_sched.sv
// Round-robin scheduler time-sharing one external unsigned a>=b comparator among NREQ requesters.
// Optional CMPGE_SETTLE_EN adds a one-cycle SETTLE state between operand issue and result capture.
module cmpge_share_sched #(
  parameter int NREQ = 4,
  parameter int W    = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic [W-1:0]      cmp_a,
  output logic [W-1:0]      cmp_b,
  input  logic              cmp_o,
  output logic              o_valid,
  output logic [IDW-1:0]    o_id,
  output logic              o_ge
);

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, EVAL} state_t;

  state_t            state, state_n;
  logic [IDW-1:0]    ptr;
  logic [IDW-1:0]    cur;
  logic [IDW-1:0]    win;
  logic              found;
  logic [NREQ-1:0]   win_onehot;
  logic              grant_now;
  logic              capture;

  // Rotating priority search starting at ptr; the first active request wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    found      = 1'b0;
    win        = '0;
    win_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      int j;
      j = (int'(ptr) + i) % NREQ;
      if (!found && req[j[IDW-1:0]]) begin
        found = 1'b1;
        win   = j[IDW-1:0];
      end
    end
    win_onehot[win] = 1'b1;
  end

  always_comb begin
    state_n   = state;
    grant_now = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_now = 1'b1;
          state_n   = ISSUE;
        end
      end
      ISSUE: begin
`ifdef CMPGE_SETTLE_EN
        state_n = SETTLE;
`else
        state_n = EVAL;
`endif
      end
      SETTLE: state_n = EVAL;
      EVAL: begin
        capture = 1'b1;
        if (found) begin
          grant_now = 1'b1;
          state_n   = ISSUE;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt     <= '0;
      cmp_a   <= '0;
      cmp_b   <= '0;
      ptr     <= '0;
      cur     <= '0;
      o_valid <= 1'b0;
      o_id    <= '0;
      o_ge    <= 1'b0;
    end else begin
      gnt     <= grant_now ? win_onehot : '0;
      o_valid <= capture;
      if (grant_now) begin
        cmp_a <= a_in[int'(win)*W +: W];
        cmp_b <= b_in[int'(win)*W +: W];
        cur   <= win;
        ptr   <= (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
      end
      // cur still names the in-flight requester here; it is only overwritten by the same edge's grant.
      if (capture) begin
        o_ge <= cmp_o;
        o_id <= cur;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
